risc32_exc_ctrl: RTL and testbench

Exception/interrupt sequencer for the CP0 register file. It owns CP0's single write port. It arbitrates between pipeline MTC0 writes and its own multi-cycle exception-entry and ERET sequences. During each sequence it stalls the pipeline, writes EPC, Cause and Status one per cycle, then flushes the pipeline and redirects the PC. It sits between the MEM stage and risc32_cp0_reg.

---
 rtl/risc32_exc_ctrl_if.sv | 35 +++
 rtl/risc32_exc_ctrl.sv | 145 ++++++++++++++
 tb/tb_risc32_exc_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/risc32_exc_ctrl_if.sv
// Signal bundle between the MEM stage / CP0 register file and the exception sequencer.
// The master side drives the requests and CP0 state; the slave side is the sequencer.
interface risc32_exc_ctrl_if;
   logic        inst_valid;
   logic        exc_req;
   logic [4:0]  exc_code;
   logic [31:0] exc_pc;
   logic        exc_bd;
   logic        eret;
   logic        mtc0_we;
   logic [4:0]  mtc0_waddr;
   logic [31:0] mtc0_data;
   logic [31:0] status;
   logic [31:0] cause;
   logic [31:0] epc;
   logic        cp0_we;
   logic [4:0]  cp0_waddr;
   logic [31:0] cp0_data;
   logic        stall;
   logic        flush;
   logic [31:0] new_pc;
   logic        busy;

   modport master (
      output inst_valid, exc_req, exc_code, exc_pc, exc_bd, eret,
             mtc0_we, mtc0_waddr, mtc0_data, status, cause, epc,
      input  cp0_we, cp0_waddr, cp0_data, stall, flush, new_pc, busy
   );

   modport slave (
      input  inst_valid, exc_req, exc_code, exc_pc, exc_bd, eret,
             mtc0_we, mtc0_waddr, mtc0_data, status, cause, epc,
      output cp0_we, cp0_waddr, cp0_data, stall, flush, new_pc, busy
   );
endinterface

// File: rtl/risc32_exc_ctrl.sv
// Exception/interrupt sequencer: owns the CP0 write port, runs exception-entry and
// ERET sequences (EPC, Cause, Status writes, then flush + PC redirect) and passes MTC0 through.
module risc32_exc_ctrl #(
   parameter logic [31:0] EXC_VECTOR = 32'h0000_0020,
   parameter logic [4:0]  INT_CODE   = 5'd0
) (
   input  logic             clk,
   input  logic             rst,
   risc32_exc_ctrl_if.slave bus
);
   typedef enum logic [2:0] {IDLE, W_EPC, W_CAUSE, W_STATUS, W_ERET, REDIRECT} state_t;

   localparam logic [4:0] REG_STATUS = 5'd12;
   localparam logic [4:0] REG_CAUSE  = 5'd13;
   localparam logic [4:0] REG_EPC    = 5'd14;

   state_t      state;
   logic        idle;
   logic        irq_pend;
   logic        take_irq;
   logic        take_exc;
   logic        take_eret;
   logic        accept;
   logic        pass;
   logic [4:0]  code_sel;
   logic [31:0] cause_next;

   // Sequence context captured at acceptance.
   logic [4:0]  code_q;
   logic        bd_q;
   logic [31:0] status_q;
   logic [31:0] cause_q;
   logic [31:0] epc_q;

   // Registered outputs for the cycle after the current one.
   logic        we_q;
   logic [4:0]  addr_q;
   logic [31:0] data_q;
   logic        flush_q;
   logic [31:0] npc_q;

   always_comb begin
      idle      = (state == IDLE);
      irq_pend  = bus.status[0] & ~bus.status[1] & (|(bus.cause[15:8] & bus.status[15:8]));
      take_irq  = bus.inst_valid & irq_pend;
      take_exc  = idle & (take_irq | bus.exc_req);
      take_eret = idle & ~take_exc & bus.eret;
      accept    = take_exc | take_eret;
      pass      = idle & ~accept & bus.mtc0_we;
      code_sel  = take_irq ? INT_CODE : bus.exc_code;

      // With EXL already set the delay-slot flag from the original exception is kept.
      cause_next      = cause_q;
      cause_next[6:2] = code_q;
      if (!status_q[1]) cause_next[31] = bd_q;
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         code_q   <= '0;
         bd_q     <= 1'b0;
         status_q <= '0;
         cause_q  <= '0;
         epc_q    <= '0;
         we_q     <= 1'b0;
         addr_q   <= '0;
         data_q   <= '0;
         flush_q  <= 1'b0;
         npc_q    <= '0;
      end else begin
         we_q    <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
         flush_q <= 1'b0;
         npc_q   <= '0;
         case (state)
            IDLE: begin
               if (take_exc) begin
                  state    <= W_EPC;
                  code_q   <= code_sel;
                  bd_q     <= bus.exc_bd;
                  status_q <= bus.status;
                  cause_q  <= bus.cause;
                  if (!bus.status[1]) begin
                     we_q   <= 1'b1;
                     addr_q <= REG_EPC;
                     data_q <= bus.exc_bd ? bus.exc_pc - 32'd4 : bus.exc_pc;
                  end
               end else if (take_eret) begin
                  state    <= W_ERET;
                  status_q <= bus.status;
                  epc_q    <= bus.epc;
                  we_q     <= 1'b1;
                  addr_q   <= REG_STATUS;
                  data_q   <= bus.status & ~32'h2;
               end
            end
            W_EPC: begin
               state  <= W_CAUSE;
               we_q   <= 1'b1;
               addr_q <= REG_CAUSE;
               data_q <= cause_next;
            end
            W_CAUSE: begin
               state  <= W_STATUS;
               we_q   <= 1'b1;
               addr_q <= REG_STATUS;
               data_q <= status_q | 32'h2;
            end
            W_STATUS: begin
               state   <= REDIRECT;
               flush_q <= 1'b1;
               npc_q   <= EXC_VECTOR;
            end
            W_ERET: begin
               state   <= REDIRECT;
               flush_q <= 1'b1;
               npc_q   <= epc_q;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // In IDLE the write port belongs to the pipeline; an MTC0 that collides with
   // an accepted request is dropped because the following flush discards it.
   always_comb begin
      if (idle) begin
         bus.cp0_we    = pass;
         bus.cp0_waddr = pass ? bus.mtc0_waddr : 5'd0;
         bus.cp0_data  = pass ? bus.mtc0_data : 32'd0;
      end else begin
         bus.cp0_we    = we_q;
         bus.cp0_waddr = addr_q;
         bus.cp0_data  = data_q;
      end
      bus.stall  = ~idle | accept;
      bus.flush  = flush_q;
      bus.new_pc = npc_q;
      bus.busy   = ~idle;
   end
endmodule

// File: tb/tb_risc32_exc_ctrl.sv
// Bench for risc32_exc_ctrl: directed scenarios then random traffic, checked cycle by
// cycle against a transaction model that expands each accepted request into its output timeline.
module tb_risc32_exc_ctrl;
   typedef struct packed {
      logic        inst_valid;
      logic        exc_req;
      logic [4:0]  exc_code;
      logic [31:0] exc_pc;
      logic        exc_bd;
      logic        eret;
      logic        mtc0_we;
      logic [4:0]  mtc0_waddr;
      logic [31:0] mtc0_data;
      logic [31:0] status;
      logic [31:0] cause;
      logic [31:0] epc;
   } stim_t;

   typedef struct packed {
      logic        we;
      logic [4:0]  addr;
      logic [31:0] data;
      logic        stall;
      logic        flush;
      logic [31:0] npc;
      logic        busy;
   } out_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   out_t exp_q[$];

   always #5 clk = ~clk;

   risc32_exc_ctrl_if bus ();

   risc32_exc_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   function automatic out_t mk(input logic we, input logic [4:0] addr, input logic [31:0] data,
                               input logic stall, input logic flush, input logic [31:0] npc,
                               input logic busy);
      out_t o;
      o = '{we: we, addr: addr, data: data, stall: stall, flush: flush, npc: npc, busy: busy};
      return o;
   endfunction

   function automatic stim_t idle_stim();
      stim_t s;
      s = '0;
      return s;
   endfunction

   task automatic apply(input stim_t s);
      bus.inst_valid = s.inst_valid;
      bus.exc_req    = s.exc_req;
      bus.exc_code   = s.exc_code;
      bus.exc_pc     = s.exc_pc;
      bus.exc_bd     = s.exc_bd;
      bus.eret       = s.eret;
      bus.mtc0_we    = s.mtc0_we;
      bus.mtc0_waddr = s.mtc0_waddr;
      bus.mtc0_data  = s.mtc0_data;
      bus.status     = s.status;
      bus.cause      = s.cause;
      bus.epc        = s.epc;
   endtask

   // Expected outputs for this cycle; an accepted request queues its whole future timeline.
   function automatic out_t model(input stim_t s);
      out_t        now;
      logic        irq;
      logic        exl;
      logic [31:0] c;
      if (exp_q.size() != 0) return exp_q.pop_front();
      irq = s.inst_valid && s.status[0] && !s.status[1] && ((s.cause[15:8] & s.status[15:8]) != 8'd0);
      exl = s.status[1];
      if (irq || s.exc_req) begin
         now = mk(0, 0, 0, 1, 0, 0, 0);
         if (exl) exp_q.push_back(mk(0, 0, 0, 1, 0, 0, 1));
         else     exp_q.push_back(mk(1, 14, s.exc_bd ? s.exc_pc - 32'd4 : s.exc_pc, 1, 0, 0, 1));
         c = s.cause;
         c[6:2] = irq ? 5'd0 : s.exc_code;
         if (!exl) c[31] = s.exc_bd;
         exp_q.push_back(mk(1, 13, c, 1, 0, 0, 1));
         exp_q.push_back(mk(1, 12, s.status | 32'h2, 1, 0, 0, 1));
         exp_q.push_back(mk(0, 0, 0, 1, 1, 32'h20, 1));
      end else if (s.eret) begin
         now = mk(0, 0, 0, 1, 0, 0, 0);
         exp_q.push_back(mk(1, 12, s.status & ~32'h2, 1, 0, 0, 1));
         exp_q.push_back(mk(0, 0, 0, 1, 1, s.epc, 1));
      end else if (s.mtc0_we) begin
         now = mk(1, s.mtc0_waddr, s.mtc0_data, 0, 0, 0, 0);
      end else begin
         now = mk(0, 0, 0, 0, 0, 0, 0);
      end
      return now;
   endfunction

   task automatic step(input stim_t s);
      out_t e;
      @(posedge clk);
      #1 apply(s);
      @(negedge clk);
      e = model(s);
      chk("cp0_we",    32'(bus.cp0_we),    32'(e.we));
      chk("cp0_waddr", 32'(bus.cp0_waddr), 32'(e.addr));
      chk("cp0_data",  bus.cp0_data,       e.data);
      chk("stall",     32'(bus.stall),     32'(e.stall));
      chk("flush",     32'(bus.flush),     32'(e.flush));
      chk("new_pc",    bus.new_pc,         e.npc);
      chk("busy",      32'(bus.busy),      32'(e.busy));
   endtask

   task automatic idle_steps(input int n);
      for (int i = 0; i < n; i++) step(idle_stim());
   endtask

   function automatic stim_t rand_stim();
      stim_t s;
      s.inst_valid = 1'($urandom_range(0, 1));
      s.exc_req    = ($urandom_range(0, 4) == 0);
      s.exc_code   = 5'($urandom);
      s.exc_pc     = $urandom;
      s.exc_bd     = 1'($urandom_range(0, 1));
      s.eret       = ($urandom_range(0, 4) == 0);
      s.mtc0_we    = 1'($urandom_range(0, 1));
      s.mtc0_waddr = 5'($urandom);
      s.mtc0_data  = $urandom;
      s.status     = $urandom;
      s.cause      = $urandom;
      s.epc        = $urandom;
      if ($urandom_range(0, 3) == 0) s.cause[15:8] = 8'h00;
      return s;
   endfunction

   initial begin
      stim_t s;
      apply(idle_stim());
      #2;
      chk("reset_cp0_we", 32'(bus.cp0_we), 0);
      chk("reset_stall",  32'(bus.stall),  0);
      chk("reset_flush",  32'(bus.flush),  0);
      chk("reset_busy",   32'(bus.busy),   0);
      chk("reset_new_pc", bus.new_pc,      0);
      @(negedge clk);
      rst = 1'b1;
      idle_steps(2);

      // Syscall
      s = idle_stim();
      s.exc_req = 1; s.exc_code = 5'd8; s.exc_pc = 32'h100; s.status = 32'h1000_0001;
      step(s);
      idle_steps(6);

      // Delay-slot overflow
      s = idle_stim();
      s.exc_req = 1; s.exc_code = 5'd12; s.exc_pc = 32'h204; s.exc_bd = 1; s.status = 32'h1;
      step(s);
      idle_steps(6);

      // Interrupt beats a simultaneous exception (and an MTC0 is dropped)
      s = idle_stim();
      s.inst_valid = 1; s.exc_req = 1; s.exc_code = 5'd10; s.status = 32'h0401;
      s.cause = 32'h0400; s.mtc0_we = 1; s.mtc0_waddr = 5'd9; s.mtc0_data = 32'h55;
      step(s);
      idle_steps(6);

      // EXL already set
      s = idle_stim();
      s.exc_req = 1; s.exc_code = 5'd8; s.exc_pc = 32'h300; s.exc_bd = 1;
      s.status = 32'h3; s.cause = 32'h8000_0000;
      step(s);
      idle_steps(6);

      // ERET
      s = idle_stim();
      s.eret = 1; s.epc = 32'h400; s.status = 32'h3;
      step(s);
      idle_steps(4);

      // Zero-PC delay slot wraps
      s = idle_stim();
      s.exc_req = 1; s.exc_code = 5'd4; s.exc_pc = 32'h0; s.exc_bd = 1;
      step(s);
      idle_steps(6);

      // MTC0 passthrough
      s = idle_stim();
      s.mtc0_we = 1; s.mtc0_waddr = 5'd11; s.mtc0_data = 32'h50;
      step(s);
      idle_steps(2);

      // Reset asserted during W_CAUSE
      s = idle_stim();
      s.exc_req = 1; s.exc_code = 5'd8; s.exc_pc = 32'h100; s.status = 32'h1;
      step(s);
      step(idle_stim());
      @(posedge clk);
      #1 apply(idle_stim());
      rst = 1'b0;
      #1;
      chk("midrst_cp0_we", 32'(bus.cp0_we), 0);
      chk("midrst_stall",  32'(bus.stall),  0);
      chk("midrst_flush",  32'(bus.flush),  0);
      chk("midrst_busy",   32'(bus.busy),   0);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b1;
      idle_steps(6);

      // Random traffic, including requests and MTC0 while busy
      for (int i = 0; i < 2000; i++) step(rand_stim());
      idle_steps(6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
